// File: rtl/mix_core_param.sv
// Parametrised state-mixing core: loads a LANES x W seed, runs ROUNDS mixing rounds
// (one per clock), then presents the result with valid/ready and optional chaining.

module mix_lane #(
  parameter int W   = 32,
  parameter int IDX = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  input  logic [W-1:0] s_prev,
  input  logic [W-1:0] t_far,
  output logic [W-1:0] t,
  output logic [W-1:0] s
);
  localparam int SH = W / 2;

  // t is exported so lane i-3 can fold it into its own update
  assign t = s + s_prev + W'(IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    s <= '0;
    else if (load) s <= seed;
    else if (step) s <= t ^ (t_far << SH);
  end
endmodule

module mix_core_param #(
  parameter int W      = 32,
  parameter int LANES  = 8,
  parameter int ROUNDS = 4,
  parameter int CW     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  input  logic               chain,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic               busy,
  output logic [CW-1:0]      job_count
);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state, state_nx;
  logic   [RW-1:0]            rnd_cnt;
  logic   [LANES-1:0][W-1:0]  s, t;
  logic                       load, step, hs, restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    hs        = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          restart  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (rnd_cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~chain;
        if (out_ready) begin
          hs = 1'b1;
          // chain wins over a pending seed; the seed stays offered for later
          if (chain) begin
            restart  = 1'b1;
            state_nx = RUN;
          end else if (in_valid) begin
            load     = 1'b1;
            restart  = 1'b1;
            state_nx = RUN;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rnd_cnt <= '0;
    else if (restart) rnd_cnt <= '0;
    else if (step)    rnd_cnt <= (rnd_cnt == LAST) ? '0 : rnd_cnt + RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        job_count <= '0;
    else if (hs && (job_count != '1))  job_count <= job_count + CW'(1);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mix_lane #(.W(W), .IDX(i)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .seed   (in_data[i*W +: W]),
      .step   (step),
      .s_prev (s[(i + LANES - 1) % LANES]),
      .t_far  (t[(i + 3) % LANES]),
      .t      (t[i]),
      .s      (s[i])
    );
  end

  assign out_data = s;
endmodule

// File: tb/tb_mix_core_param.sv
// Directed bench for mix_core_param: three instances cover ROUNDS=1, ROUNDS=4 and CW=2.
module tb_mix_core_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // a: ROUNDS=1
  logic a_iv = 0, a_ir, a_ch = 0, a_ov, a_or = 0, a_busy;
  logic [255:0] a_id = '0, a_od;
  logic [15:0]  a_jc;
  // b: ROUNDS=4
  logic b_iv = 0, b_ir, b_ch = 0, b_ov, b_or = 0, b_busy;
  logic [255:0] b_id = '0, b_od;
  logic [15:0]  b_jc;
  // c: ROUNDS=1, CW=2
  logic c_iv = 0, c_ir, c_ch = 0, c_ov, c_or = 0, c_busy;
  logic [255:0] c_id = '0, c_od;
  logic [1:0]   c_jc;

  mix_core_param #(.W(32), .LANES(8), .ROUNDS(1), .CW(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .chain(a_ch), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .busy(a_busy), .job_count(a_jc));

  mix_core_param #(.W(32), .LANES(8), .ROUNDS(4), .CW(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .chain(b_ch), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .busy(b_busy), .job_count(b_jc));

  mix_core_param #(.W(32), .LANES(8), .ROUNDS(1), .CW(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .chain(c_ch), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
    .busy(c_busy), .job_count(c_jc));

  // Reference round for W=32, LANES=8
  function automatic logic [255:0] ref_round(input logic [255:0] s);
    logic [31:0] t [8];
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      t[i] = s[i*32 +: 32] + s[((i + 7) % 8)*32 +: 32] + 32'(i);
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = t[i] ^ (t[(i + 3) % 8] << 16);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [255:0] seed;
    seed = {8{32'hA5A5_0F0F}};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    b_id = seed; b_iv = 1'b1;
    tick();
    b_iv = 1'b0;
    tick();
    checks++;
    if (b_busy !== 1'b1) begin failures++; $display("FAIL reset_prebusy got=%b exp=1", b_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({b_ov, b_busy, b_ir} !== 3'b001) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=001", {b_ov, b_busy, b_ir});
    end
    checks++;
    if (b_jc !== 16'd0) begin failures++; $display("FAIL reset_jc got=%0d exp=0", b_jc); end
    checks++;
    if (b_od !== 256'd0) begin failures++; $display("FAIL reset_od got=%h exp=0", b_od); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round1();
    logic [255:0] exp;
    exp = {32'h0002_0007, 32'h0001_0006, 32'h0000_0005, 32'h0007_0004,
           32'h0006_0003, 32'h0005_0002, 32'h0004_0001, 32'h0003_0000};
    a_id = '0; a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    checks++;
    if (a_ov !== 1'b0 || a_busy !== 1'b1) begin
      failures++; $display("FAIL r1_run got=%b%b exp=01", a_ov, a_busy);
    end
    tick();
    checks++;
    if (a_ov !== 1'b1) begin failures++; $display("FAIL r1_valid got=%b exp=1", a_ov); end
    checks++;
    if (a_od !== exp) begin failures++; $display("FAIL r1_data got=%h exp=%h", a_od, exp); end
  endtask

  task automatic test_chain();
    logic [255:0] first, exp2;
    first = {32'h0002_0007, 32'h0001_0006, 32'h0000_0005, 32'h0007_0004,
             32'h0006_0003, 32'h0005_0002, 32'h0004_0001, 32'h0003_0000};
    exp2 = ref_round(first);
    a_or = 1'b1; a_ch = 1'b1; a_iv = 1'b1; a_id = {8{32'hDEAD_BEEF}};
    #1;
    checks++;
    if (a_ir !== 1'b0) begin failures++; $display("FAIL chain_inready got=%b exp=0", a_ir); end
    tick();
    a_ch = 1'b0; a_or = 1'b0;
    checks++;
    if (a_jc !== 16'd1 || a_busy !== 1'b1) begin
      failures++; $display("FAIL chain_hs1 got=jc%0d busy%b exp=jc1 busy1", a_jc, a_busy);
    end
    tick();
    a_iv = 1'b0;
    checks++;
    if (a_ov !== 1'b1 || a_od !== exp2) begin
      failures++; $display("FAIL chain_data got=%h exp=%h", a_od, exp2);
    end
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    checks++;
    if (a_jc !== 16'd2 || a_ov !== 1'b0 || a_ir !== 1'b1) begin
      failures++; $display("FAIL chain_hs2 got=jc%0d ov%b ir%b exp=jc2 ov0 ir1", a_jc, a_ov, a_ir);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] seed, exp;
    int bad;
    for (int i = 0; i < 8; i++) seed[i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
    exp = ref_round(ref_round(ref_round(ref_round(seed))));
    b_id = seed; b_iv = 1'b1;
    tick();
    b_iv = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (b_ov !== 1'b0) begin failures++; $display("FAIL bp_early got=%b exp=0", b_ov); end
    tick();
    checks++;
    if (b_ov !== 1'b1 || b_od !== exp) begin
      failures++; $display("FAIL bp_result got=%h exp=%h", b_od, exp);
    end
    b_iv = 1'b1; b_id = {8{32'h5555_AAAA}};
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (b_od !== exp || b_ov !== 1'b1 || b_ir !== 1'b0 || b_jc !== 16'd0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d_bad_cycles exp=0", bad); end
    b_iv = 1'b0; b_or = 1'b1;
    tick();
    b_or = 1'b0;
    checks++;
    if (b_jc !== 16'd1 || b_ov !== 1'b0) begin
      failures++; $display("FAIL bp_release got=jc%0d ov%b exp=jc1 ov0", b_jc, b_ov);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] sa, sb, exp;
    int bad;
    sa = {8{32'h0123_4567}};
    sb = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    exp = ref_round(ref_round(ref_round(ref_round(sb))));
    b_id = sa; b_iv = 1'b1;
    tick();
    b_iv = 1'b0;
    tick(); tick(); tick(); tick();
    b_or = 1'b1; b_iv = 1'b1; b_id = sb;
    #1;
    checks++;
    if (b_ir !== 1'b1 || b_ov !== 1'b1) begin
      failures++; $display("FAIL b2b_ready got=ir%b ov%b exp=ir1 ov1", b_ir, b_ov);
    end
    tick();
    b_or = 1'b0; b_iv = 1'b0;
    checks++;
    if (b_jc !== 16'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", b_jc); end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (b_busy !== 1'b1 || b_ov !== 1'b0) bad++;
      if (k < 3) tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL b2b_noidle got=%0d_bad_cycles exp=0", bad); end
    tick();
    checks++;
    if (b_ov !== 1'b1 || b_od !== exp) begin
      failures++; $display("FAIL b2b_result got=%h exp=%h", b_od, exp);
    end
    b_or = 1'b1;
    tick();
    b_or = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp [5];
    exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int j = 0; j < 5; j++) begin
      c_id = {8{32'(j)}}; c_iv = 1'b1;
      tick();
      c_iv = 1'b0;
      tick();
      c_or = 1'b1;
      tick();
      c_or = 1'b0;
      checks++;
      if (c_jc !== exp[j]) begin
        failures++; $display("FAIL sat_job%0d got=%0d exp=%0d", j, c_jc, exp[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round1();
    test_chain();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mix_core_param.md
Name: mix_core_param

Overview:
- Parametrised, handshaked successor to the team's fixed 8×32-bit state-mixing benchmark core.
- Accepts a seed vector of LANES words of W bits and applies ROUNDS mixing rounds, one round per clock.
- Presents the result with valid/ready and can optionally chain the result straight into another job.
- Used as a simulator-throughput workload and as a reusable scrambler lane block.

Parameters:
- W, 32, lane word width in bits; even, >= 8.
- LANES, 8, number of lanes; >= 4.
- ROUNDS, 4, rounds per job; >= 1.
- CW, 16, width of the completed-job counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  seed offered.
- in_ready  output  1  core can accept a seed this cycle.
- in_data  input  LANES*W  seed; lane i is bits [i*W +: W].
- chain  input  1  sampled at the output handshake; 1 restarts RUN on the result instead of returning to IDLE.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  LANES*W  result state; lane packing as for in_data.
- busy  output  1  high in RUN.
- job_count  output  CW  number of completed output handshakes; saturating.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all lane registers s[i] = 0.
  - Round counter = 0; job_count = 0.
  - Outputs: out_valid = 0, busy = 0, in_ready = 1, out_data = 0.
- Round function (all lanes update simultaneously from the old state s; arithmetic mod 2^W; SH = W/2; indices mod LANES):
  - t[i] = s[i] + s[i-1] + i (i zero-extended to W).
  - s'[i] = t[i] XOR (t[i+3] << SH), where `<<` is a logical shift truncated to W bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: s <= in_data, round counter <= 0, go to RUN.
- RUN:
  - busy = 1, in_ready = 0.
  - Each cycle s <= round(s) and the counter increments.
  - After the ROUNDS-th update, go to DONE.
  - Latency: seed accepted at edge k → out_valid high after edge k+ROUNDS.
- DONE:
  - out_valid = 1; out_data = s, held stable while out_ready = 0. s does not change in DONE.
  - On out_valid & out_ready, job_count increments, saturating at 2^CW-1.
  - Then, on that same edge:
    - chain = 1: go to RUN with s retained and counter = 0. The seed port is ignored and in_ready = 0.
    - chain = 0 and in_valid = 1: accept the new seed on the same edge (back-to-back), go to RUN. in_ready = out_ready & ~chain in DONE.
    - chain = 0 and in_valid = 0: go to IDLE.
- in_ready is 0 in RUN and in DONE without out_ready. in_valid in those cycles is ignored; no seed is lost because no handshake occurs.
- out_data outside DONE: holds the last s value. Consumers qualify it with out_valid only.
- Reset mid-RUN or mid-DONE: the job is discarded immediately, with no output handshake and no count.
- Combinational paths: in_ready depends combinationally on out_ready and chain in DONE only. There is no other input→output combinational path.
- Width rules: all adds wrap; no carries are kept. The shift discards bits beyond W.

Test Plan (defaults W=32, LANES=8, CW=16 unless stated):
- Reset values:
  - Stimulus: assert rst_n=0 mid-RUN.
  - Required: out_valid=0, busy=0, in_ready=1, job_count=0 immediately (asynchronously); out_data=0.
- ROUNDS=1, zero seed:
  - Stimulus: handshake seed = 0 at edge k.
  - Required: out_valid high after edge k+1; lanes 0..7 = 0x00030000, 0x00040001, 0x00050002, 0x00060003, 0x00070004, 0x00000005, 0x00010006, 0x00020007.
- Backpressure (ROUNDS=4):
  - Stimulus: hold out_ready=0 for 10 cycles in DONE.
  - Required: out_data stable, out_valid stays 1, in_ready=0, job_count unchanged; on out_ready=1, job_count=1.
- Back-to-back:
  - Stimulus: in_valid=1 with out_ready=1, chain=0 in DONE.
  - Required: new seed accepted on the same edge; the next out_valid exactly ROUNDS cycles later; no IDLE cycle.
- Chain:
  - Stimulus: ROUNDS=1, zero seed, chain=1 at the first output handshake.
  - Required: the second result equals the round function applied to the first result (bench reference model); in_valid ignored; job_count=2 after the second handshake.
- Saturation:
  - Stimulus: CW=2, complete 5 jobs.
  - Required: job_count reads 1, 2, 3, 3, 3.
